div_period_meter: RTL and testbench

- Receive-side checker for the clock-divider outputs.
- Takes one divided signal looped back from a pad (asynchronous to clk), synchronizes it, and measures the clk-cycle count between consecutive rising edges.
- Delivers each result on a valid/ready interface for bring-up logic or a logic-analyzer readout.
- Flags timeouts (no edge) and dropped results (overrun).

---
 rtl/div_meter_pkg.sv | 13 +
 rtl/div_period_meter_edge_sync.sv | 30 +++
 rtl/div_period_meter.sv | 172 +++++++++++++++++
 tb/tb_div_period_meter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_meter_pkg.sv
// Shared types and default sizes for the divider period meter.
package div_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } meter_state_e;

    localparam int DEF_CNT_W       = 24;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/div_period_meter_edge_sync.sv
// Synchronizer chain, history flop and registered rising-edge pulse for the
// asynchronous looped-back divider signal; input-to-pulse latency is SYNC_STAGES+1.
module div_edge_sync
    import div_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   hist_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            hist_p1 <= 1'b0;
            edge_o  <= 1'b0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], d_i};
            // --- stage: history and edge pulse ---
            hist_p1 <= sync_p0[SYNC_STAGES-1];
            edge_o  <= sync_p0[SYNC_STAGES-1] & ~hist_p1;
        end
    end

endmodule

// File: rtl/div_period_meter.sv
// Measures clk cycles between rising edges of a looped-back divider output and
// delivers results over valid/ready. Optional averaging: define DIV_METER_AVG_EN.
module div_period_meter
    import div_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int AVG_LOG2    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             timeout_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             edge_p1;
    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             meas_vld, meas_timeout;
    logic [CNT_W-1:0] meas_period;
    logic             res_vld, res_timeout;
    logic [CNT_W-1:0] res_period;

    div_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sig_i),
        .edge_o(edge_p1)
    );

    // --- stage: period counter and FSM ---
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        meas_vld     = 1'b0;
        meas_timeout = 1'b0;
        meas_period  = cnt_q;
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    cnt_d = '0;
                    if (edge_p1) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (edge_p1) begin
                        meas_vld = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // no edge within the counter range: report and re-arm
                        meas_vld     = 1'b1;
                        meas_timeout = 1'b1;
                        cnt_d        = '0;
                        state_d      = ARM;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DIV_METER_AVG_EN
    // --- stage: averaging accumulator ---
    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int NUM_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [NUM_W-1:0] NUM_LAST = NUM_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q, acc_sum;
    logic [NUM_W-1:0] num_q;

    function automatic logic [CNT_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] shifted;
        shifted = sum >> AVG_LOG2;
        return shifted[CNT_W-1:0];
    endfunction

    assign acc_sum = acc_q + ACC_W'(meas_period);

    always_comb begin
        res_vld     = 1'b0;
        res_period  = meas_period;
        res_timeout = meas_timeout;
        if (meas_vld) begin
            if (meas_timeout) begin
                res_vld = 1'b1;
            end else if (num_q == NUM_LAST) begin
                res_vld    = 1'b1;
                res_period = avg_trunc(acc_sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en_i) begin
            acc_q <= '0;
            num_q <= '0;
        end else if (meas_vld) begin
            if (meas_timeout || num_q == NUM_LAST) begin
                acc_q <= '0;
                num_q <= '0;
            end else begin
                acc_q <= acc_sum;
                num_q <= NUM_W'(num_q + 1'b1);
            end
        end
    end
`else
    logic unused_avg;
    assign unused_avg  = ^AVG_LOG2;
    assign res_vld     = meas_vld;
    assign res_period  = meas_period;
    assign res_timeout = meas_timeout;
`endif

    // --- stage: output holding register ---
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_o  <= '0;
            timeout_o <= 1'b0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (!en_i) begin
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else if (res_vld) begin
            if (valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else begin
                period_o  <= res_period;
                timeout_o <= res_timeout;
                valid_o   <= 1'b1;
            end
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_period_meter.sv
// Directed bench for div_period_meter: table of square-wave periods plus
// sequences for latency, backpressure, timeout, enable drop and reset.
module tb_div_period_meter;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n, en_i, sig_i, ready_i;
    logic [CNT_W-1:0] period_o;
    logic             valid_o, timeout_o, overrun_o;

    int checks   = 0;
    int failures = 0;

    int   g_mode, g_hi, g_lo_a, g_lo_b, g_ph;
    logic g_level;
    bit   g_alt;

    typedef struct {
        int hi;
        int lo;
        int exp_period;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    div_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(2),
        .AVG_LOG2   (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_i),
        .sig_i    (sig_i),
        .period_o (period_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .timeout_o(timeout_o),
        .overrun_o(overrun_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance to the next falling edge and update the signal generator there
    task automatic tick();
        @(negedge clk);
        if (g_mode == 1) begin
            sig_i = (g_ph < g_hi);
            g_ph++;
            if (g_ph == g_hi + (g_alt ? g_lo_b : g_lo_a)) begin
                g_ph  = 0;
                g_alt = !g_alt;
            end
        end else begin
            sig_i = g_level;
        end
    endtask

    task automatic start_sq(input int hi, input int lo_a, input int lo_b);
        g_mode = 1; g_hi = hi; g_lo_a = lo_a; g_lo_b = lo_b; g_ph = 0; g_alt = 1'b0;
    endtask

    task automatic hold(input logic lvl);
        g_mode = 0; g_level = lvl;
    endtask

    task automatic rearm();
        en_i = 1'b0;
        hold(1'b0);
        repeat (4) tick();
        en_i = 1'b1;
        repeat (3) tick();
    endtask

    // first result needs two edges: valid appears n+5 ticks after the first rise
    task automatic check_first(input string name, input int hi, input int lo, input int n);
        start_sq(hi, lo, lo);
        repeat (n + 4) tick();
        check({name, "_early"}, 32'(valid_o), 0);
        tick();
        check({name, "_valid"}, 32'(valid_o), 1);
        check({name, "_period"}, 32'(period_o), n);
        check({name, "_timeout"}, 32'(timeout_o), 0);
    endtask

    task automatic wait_result(input string name, input int exp_p, input int exp_to,
                               input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!valid_o && waited < budget);
        check({name, "_arrived"}, 32'(valid_o), 1);
        check({name, "_period"}, 32'(period_o), exp_p);
        check({name, "_timeout"}, 32'(timeout_o), exp_to);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0] = '{hi: 1, lo: 1, exp_period: 2};
        vecs[1] = '{hi: 1, lo: 3, exp_period: 4};
        vecs[2] = '{hi: 2, lo: 2, exp_period: 4};
        vecs[3] = '{hi: 3, lo: 3, exp_period: 6};
        vecs[4] = '{hi: 4, lo: 3, exp_period: 7};
        vecs[5] = '{hi: 5, lo: 5, exp_period: 10};
        vecs[6] = '{hi: 7, lo: 6, exp_period: 13};

        rst_n = 1'b0; en_i = 1'b0; ready_i = 1'b1; sig_i = 1'b0;
        hold(1'b0);
        repeat (3) tick();
        check("rst_period", 32'(period_o), 0);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        check("rst_overrun", 32'(overrun_o), 0);
        rst_n = 1'b1;

`ifndef DIV_METER_AVG_EN
        // divide-by-10: exact first latency, then one result every 10 cycles
        rearm();
        check_first("div10_first", 5, 5, 10);
        for (int r = 0; r < 2; r++) begin
            wait_result($sformatf("div10_next%0d", r), 10, 0, 15, w);
            check($sformatf("div10_spacing%0d", r), 32'(w), 10);
        end

        for (int i = 0; i < 7; i++) begin
            rearm();
            ready_i = 1'b1;
            start_sq(vecs[i].hi, vecs[i].lo, vecs[i].lo);
            for (int r = 0; r < 3; r++) begin
                wait_result($sformatf("vec%0d_r%0d", i, r), vecs[i].exp_period, 0,
                            3 * vecs[i].exp_period + 10, w);
                if (r > 0)
                    check($sformatf("vec%0d_spacing%0d", i, r), 32'(w), vecs[i].exp_period);
                check($sformatf("vec%0d_overrun%0d", i, r), 32'(overrun_o), 0);
            end
        end

        // backpressure on a divide-by-4 input
        rearm();
        ready_i = 1'b0;
        start_sq(2, 2, 2);
        wait_result("bp_first", 4, 0, 20, w);
        check("bp_first_overrun", 32'(overrun_o), 0);
        for (int j = 1; j <= 12; j++) begin
            tick();
            check($sformatf("bp_hold_valid%0d", j), 32'(valid_o), 1);
            check($sformatf("bp_hold_period%0d", j), 32'(period_o), 4);
            if (j == 3) check("bp_overrun_before_2nd", 32'(overrun_o), 0);
        end
        check("bp_overrun_sticky", 32'(overrun_o), 1);
        ready_i = 1'b1;
        tick();
        check("bp_drop_after_accept", 32'(valid_o), 0);
        repeat (3) tick();
        check("bp_next_result", 32'(valid_o), 1);
        ready_i = 1'b0;
        repeat (3) tick();
        check("bp_next_held", 32'(valid_o), 1);
        ready_i = 1'b1;
        tick();
        check("bp_coincide_valid", 32'(valid_o), 1);
        check("bp_coincide_period", 32'(period_o), 4);
        tick();
        check("bp_coincide_drop", 32'(valid_o), 0);

        // enable drop while a result is held and overrun is set
        ready_i = 1'b0;
        wait_result("en_setup", 4, 0, 8, w);
        repeat (5) tick();
        check("en_pre_valid", 32'(valid_o), 1);
        check("en_pre_overrun", 32'(overrun_o), 1);
        en_i = 1'b0;
        hold(1'b0);
        tick();
        check("en_drop_valid", 32'(valid_o), 0);
        check("en_drop_overrun", 32'(overrun_o), 0);
        repeat (3) tick();
        en_i = 1'b1;
        ready_i = 1'b1;
        repeat (3) tick();
        check_first("en_reenable", 2, 2, 4);

        // timeout with an 8-bit counter: one edge, then constant high
        rearm();
        ready_i = 1'b1;
        hold(1'b1);
        repeat (259) tick();
        check("to_early", 32'(valid_o), 0);
        tick();
        check("to_valid", 32'(valid_o), 1);
        check("to_period", 32'(period_o), 255);
        check("to_flag", 32'(timeout_o), 1);
        hold(1'b0);
        repeat (4) tick();
        check("to_valid_dropped", 32'(valid_o), 0);
        check_first("to_resume", 3, 3, 6);

        // synchronous reset in the middle of a measurement
        rearm();
        ready_i = 1'b0;
        start_sq(5, 5, 5);
        wait_result("rst_setup", 10, 0, 30, w);
        repeat (12) tick();
        check("rst_pre_overrun", 32'(overrun_o), 1);
        hold(1'b0);
        rst_n = 1'b0;
        tick();
        check("rstmid_period", 32'(period_o), 0);
        check("rstmid_valid", 32'(valid_o), 0);
        check("rstmid_timeout", 32'(timeout_o), 0);
        check("rstmid_overrun", 32'(overrun_o), 0);
        rst_n = 1'b1;
        ready_i = 1'b1;
        repeat (4) tick();
        check_first("rst_restart", 5, 5, 10);
`else
        // pairs of periods averaged with truncation
        rearm();
        ready_i = 1'b1;
        start_sq(5, 5, 7);
        wait_result("avg_10_12_a", 11, 0, 60, w);
        wait_result("avg_10_12_b", 11, 0, 30, w);
        check("avg_10_12_spacing", 32'(w), 22);
        check("avg_overrun", 32'(overrun_o), 0);
        rearm();
        start_sq(5, 5, 6);
        wait_result("avg_10_11_a", 10, 0, 60, w);
        wait_result("avg_10_11_b", 10, 0, 30, w);
        check("avg_10_11_spacing", 32'(w), 21);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
